// File: rtl/apb_spi_master.sv
// APB requester for the SPI bridge: one command -> SETUP + ACCESS, response pulse the cycle after completion.
// Zero-wait latency accept->rsp_valid is 3 cycles; cmd_ready low while busy, PREADY stalls bounded by watchdog.
module apb_spi_master #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 1,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort when the wait that is ending would bring the count up to TIMEOUT.
  localparam logic [CW-1:0] LAST_WAIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          done;
  logic          abort;
  logic          accept;

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    abort     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if ((TIMEOUT > 0) && (wait_cnt == LAST_WAIT)) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign PSEL      = (state != IDLE);
  assign PENABLE   = (state == ACCESS);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= done | abort;
      rsp_rdata   <= (done && !PWRITE) ? PRDATA : '0;
      rsp_err     <= done ? PSLVERR : abort;
      rsp_timeout <= abort;
      if (accept) begin
        PWRITE   <= cmd_write;
        PADDR    <= cmd_addr;
        PWDATA   <= cmd_write ? cmd_wdata : '0;
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !PREADY && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_apb_spi_master.sv
// Directed bench for apb_spi_master: vector table of single transfers plus hand-written corner sequences.
module tb_apb_spi_master;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [0:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [0:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  int checks   = 0;
  int failures = 0;

  apb_spi_master #(.DATA_W(8), .ADDR_W(1), .TIMEOUT(16)) dut (
    .PCLK        (clk),
    .PRESET      (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (psel),
    .PENABLE     (penable),
    .PWRITE      (pwrite),
    .PADDR       (paddr),
    .PWDATA      (pwdata),
    .PRDATA      (prdata),
    .PREADY      (pready),
    .PSLVERR     (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       wr;
    bit [0:0] addr;
    bit [7:0] wdata;
    int       waits;      // ACCESS cycles with PREADY=0 before PREADY=1 (>=16 means never)
    bit [7:0] prdata;
    bit       slverr;
    bit [7:0] exp_rdata;
    bit       exp_err;
    bit       exp_to;
    int       exp_acc;    // ACCESS cycles observed
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    logic [7:0] expw;
    int  acc;
    bit  unstable;
    expw = v.wr ? v.wdata : 8'h00;
    chk($sformatf("v%0d idle cmd_ready", idx), cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    tick();
    // Scramble the command port: it must be ignored while busy.
    cmd_valid = 1'b0;
    cmd_write = ~v.wr;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    // Responder noise during SETUP must be ignored.
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 8'h99;
    chk($sformatf("v%0d setup psel", idx), psel, 1);
    chk($sformatf("v%0d setup penable", idx), penable, 0);
    chk($sformatf("v%0d setup pwdata", idx), pwdata, expw);
    chk($sformatf("v%0d setup cmd_ready", idx), cmd_ready, 0);
    tick();
    acc = 0;
    unstable = 1'b0;
    for (int n = 0; n < 40 && penable; n++) begin
      if (psel !== 1'b1 || paddr !== v.addr || pwrite !== v.wr || pwdata !== expw || rsp_valid !== 1'b0)
        unstable = 1'b1;
      if (n == v.waits) begin
        pready  = 1'b1;
        prdata  = v.prdata;
        pslverr = v.slverr;
      end else begin
        pready  = 1'b0;
        prdata  = 8'($urandom);
        pslverr = 1'($urandom);
      end
      tick();
      acc++;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 8'h00;
    if (penable) begin
      chk($sformatf("v%0d access bound expired", idx), penable, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end else begin
      chk($sformatf("v%0d access stable", idx), unstable, 0);
      chk($sformatf("v%0d access cycles", idx), acc, v.exp_acc);
      chk($sformatf("v%0d rsp_valid", idx), rsp_valid, 1);
      chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d rsp_err", idx), rsp_err, v.exp_err);
      chk($sformatf("v%0d rsp_timeout", idx), rsp_timeout, v.exp_to);
      chk($sformatf("v%0d rsp psel", idx), psel, 0);
      chk($sformatf("v%0d rsp cmd_ready", idx), cmd_ready, 1);
      tick();
      chk($sformatf("v%0d rsp pulse ends", idx), {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
    end
  endtask

  initial begin
    int  seen;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 1'b0;
    cmd_wdata = 8'h00;
    prdata    = 8'h00;
    pready    = 1'b0;
    pslverr   = 1'b0;

    //            wr addr wdata  waits prdata slverr exp_rd exp_err exp_to acc
    vecs[0] = '{1'b1, 1'b1, 8'hA5,  0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0,  1};
    vecs[1] = '{1'b0, 1'b0, 8'h00,  3, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0,  4};
    vecs[2] = '{1'b1, 1'b1, 8'h5A,  1, 8'hEE, 1'b1, 8'h00, 1'b1, 1'b0,  2};
    vecs[3] = '{1'b0, 1'b0, 8'h00,  0, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0,  1};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 99, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 16};
    vecs[5] = '{1'b1, 1'b1, 8'h81, 15, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 16};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 15, 8'h7E, 1'b0, 8'h7E, 1'b0, 1'b0, 16};
    vecs[7] = '{1'b1, 1'b1, 8'h00, 99, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b1, 16};

    // Reset state
    tick();
    tick();
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset apb outputs", {psel, penable, pwrite, paddr, pwdata}, 0);
    chk("reset rsp outputs", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

    // Held cmd_valid: second command accepted in the rsp_valid cycle, one IDLE cycle between PSELs
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 1'b1;
    cmd_wdata = 8'h11;
    pready    = 1'b1;
    tick();
    cmd_wdata = 8'h22;
    chk("b2b setup1 psel", psel, 1);
    tick();
    chk("b2b access1 pwdata", {penable, pwdata}, {1'b1, 8'h11});
    tick();
    chk("b2b gap idle", {rsp_valid, cmd_ready, psel}, 3'b110);
    tick();
    cmd_valid = 1'b0;
    chk("b2b setup2", {psel, penable, pwdata}, {2'b10, 8'h22});
    tick();
    chk("b2b access2", penable, 1);
    tick();
    pready = 1'b0;
    chk("b2b rsp2", {rsp_valid, rsp_err, psel}, 3'b100);
    tick();

    // Reset while in ACCESS: everything drops, no response for the killed transfer
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("rst-mid in access", {psel, penable}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst-mid outputs cleared", {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
    seen = 0;
    pready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (rsp_valid) seen++;
    end
    pready = 1'b0;
    chk("rst-mid no rsp_valid", seen, 0);
    run_txn(8, vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
